// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall arbitration, exception flush sequencing, stall statistics and watchdog
module pipe_stall_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          WDOG_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        excp_req_i,
  input  logic        excp_is_eret_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_total_o,
  output logic        wdog_err_o
);

  localparam int CW = $clog2(WDOG_LIMIT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(WDOG_LIMIT);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   new_pc_q, new_pc_d;
  logic [31:0]   total_q, total_d;
  logic [CW-1:0] run_q, run_d;
  logic          err_q, err_d;
  logic [5:0]    stall_req;

  // Deepest requesting stage wins; it and every stage in front of it stop.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem_i) begin
      stall_req = 6'b011111;
    end else if (stallreq_ex_i) begin
      stall_req = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_req = 6'b000111;
    end
  end

  // Requests are masked while the pipeline is being cleared or held in reset.
  always_comb begin
    stall = stall_req;
    if (rst || state_q == FLUSH) begin
      stall = 6'b000000;
    end
  end

  // Next state, redirect target and statistics.
  always_comb begin
    state_d  = RUN;
    new_pc_d = new_pc_q;
    total_d  = total_q;
    run_d    = '0;
    err_d    = err_q;

    if (state_q == RUN && excp_req_i) begin
      state_d  = FLUSH;
      new_pc_d = excp_is_eret_i ? epc_i : EXC_VECTOR;
    end

    if (stall[0]) begin
      if (total_q != 32'hFFFF_FFFF) begin
        total_d = total_q + 32'd1;
      end
      run_d = (run_q == LIMIT) ? run_q : run_q + 1'b1;
    end

    if (run_d == LIMIT) begin
      err_d = 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      new_pc_q <= 32'd0;
      total_q  <= 32'd0;
      run_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
      total_q  <= total_d;
      run_q    <= run_d;
      err_q    <= err_d;
    end
  end

  assign flush         = (state_q == FLUSH);
  assign new_pc        = new_pc_q;
  assign stall_total_o = total_q;
  assign wdog_err_o    = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and randomized checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        excp_req_i, excp_is_eret_i;
  logic [31:0] epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_total_o;
  logic        wdog_err_o;

  int vectors = 0;
  int errors  = 0;

  logic        m_flush;
  logic [31:0] m_pc;
  logic [31:0] m_total;
  int          m_run;
  logic        m_err;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.EXC_VECTOR(32'h0000_0020), .WDOG_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .excp_req_i     (excp_req_i),
    .excp_is_eret_i (excp_is_eret_i),
    .epc_i          (epc_i),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall_total_o  (stall_total_o),
    .wdog_err_o     (wdog_err_o)
  );

  function automatic logic [5:0] exp_stall();
    int n;
    if (rst || m_flush) return 6'b0;
    n = stallreq_mem_i ? 5 : stallreq_ex_i ? 4 : stallreq_id_i ? 3 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("new_pc", new_pc, m_pc);
    chk("stall_total", stall_total_o, m_total);
    chk("wdog_err", 32'(wdog_err_o), 32'(m_err));
  endtask

  task automatic model_update();
    logic [5:0] s;
    s = exp_stall();
    if (rst) begin
      m_flush = 1'b0; m_pc = 32'd0; m_total = 32'd0; m_run = 0; m_err = 1'b0;
    end else if (m_flush) begin
      m_flush = 1'b0;
      m_run   = 0;
    end else begin
      if (s[0]) begin
        if (m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
        if (m_run < LIMIT) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= LIMIT) m_err = 1'b1;
      if (excp_req_i) begin
        m_flush = 1'b1;
        m_pc    = excp_is_eret_i ? epc_i : 32'h0000_0020;
      end
    end
  endtask

  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_req(input logic id, input logic ex, input logic mem);
    stallreq_id_i = id; stallreq_ex_i = ex; stallreq_mem_i = mem;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m_flush = 1'b0; m_pc = 32'd0; m_total = 32'd0; m_run = 0; m_err = 1'b0;
    rst = 1'b1; excp_req_i = 1'b0; excp_is_eret_i = 1'b0; epc_i = 32'd0;
    set_req(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_total", stall_total_o, 32'h0);
    chk("rst_wdog", 32'(wdog_err_o), 32'h0);
    tick();

    set_req(1'b1, 1'b0, 1'b0); #1 chk("prio_id", 32'(stall), 32'h07); tick();
    set_req(1'b1, 1'b1, 1'b0); #1 chk("prio_id_ex", 32'(stall), 32'h0F); tick();
    set_req(1'b1, 1'b1, 1'b1); #1 chk("prio_all", 32'(stall), 32'h1F); tick();
    set_req(1'b0, 1'b0, 1'b0); #1 chk("prio_release", 32'(stall), 32'h00); tick();

    set_req(1'b0, 1'b1, 1'b0);
    excp_req_i = 1'b1;
    #1 chk("excp_same_stall", 32'(stall), 32'h0F);
    tick();
    excp_req_i = 1'b0;
    #1;
    chk("excp_flush", 32'(flush), 32'h1);
    chk("excp_new_pc", new_pc, 32'h20);
    chk("excp_flush_stall", 32'(stall), 32'h00);
    tick();
    #1;
    chk("excp_after_flush", 32'(flush), 32'h0);
    chk("excp_after_stall", 32'(stall), 32'h0F);
    tick();
    set_req(1'b0, 1'b0, 1'b0);

    excp_req_i = 1'b1; excp_is_eret_i = 1'b1; epc_i = 32'h0000_1234;
    tick();
    #1 chk("eret_f1", 32'(flush), 32'h1); chk("eret_pc1", new_pc, 32'h1234);
    tick();
    #1 chk("eret_f2", 32'(flush), 32'h0);
    tick();
    excp_req_i = 1'b0; excp_is_eret_i = 1'b0;
    #1 chk("eret_f3", 32'(flush), 32'h1); chk("eret_pc3", new_pc, 32'h1234);
    tick();

    do_reset();
    set_req(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 63; i++) tick();
    set_req(1'b0, 1'b0, 1'b0);
    #1 chk("wd63_err", 32'(wdog_err_o), 32'h0); chk("wd63_total", stall_total_o, 32'd63);
    tick();
    set_req(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) tick();
    set_req(1'b0, 1'b0, 1'b0);
    #1 chk("wd64_err", 32'(wdog_err_o), 32'h1);
    for (int i = 0; i < 5; i++) tick();
    #1 chk("wd_sticky", 32'(wdog_err_o), 32'h1);
    do_reset();
    #1 chk("wd_rst", 32'(wdog_err_o), 32'h0);

    excp_req_i = 1'b1;
    tick();
    rst = 1'b1;
    #1 chk("rstfl_flush", 32'(flush), 32'h1);
    tick();
    rst = 1'b0; excp_req_i = 1'b0;
    #1 chk("rstfl_after", 32'(flush), 32'h0); chk("rstfl_pc", new_pc, 32'h0);
    tick();

    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        if (ph % 2 == 0) begin
          rst        = ($urandom_range(99) == 0);
          excp_req_i = ($urandom_range(7) == 0);
          set_req(1'($urandom), 1'($urandom), 1'($urandom));
        end else begin
          rst        = ($urandom_range(999) == 0);
          excp_req_i = ($urandom_range(199) == 0);
          set_req(($urandom_range(9) != 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0));
        end
        excp_is_eret_i = 1'($urandom);
        epc_i          = $urandom;
        tick();
      end
    end

    rst = 1'b0; excp_req_i = 1'b0;
    set_req(1'b0, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline control unit that drives the 6-bit `stall` vector consumed by every pipeline register (pc, if/id, id/ex, ex/mem, mem/wb, wb). It arbitrates stall requests from the id, ex and mem stages. It sequences a one-cycle pipeline flush with PC redirect on exception or eret. It also keeps stall-cycle statistics and a stuck-stall watchdog. It sits beside the pipeline registers and answers their stall protocol: a stage that stops while its successor runs injects a bubble.

## Interface
- `EXC_VECTOR`, 32'h0000_0020, exception handler PC driven on `new_pc` for non-eret flushes
- `WDOG_LIMIT`, 64, consecutive stalled cycles that trip the watchdog (≥2)
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, synchronous, active-high
- `stallreq_id_i` input 1: id stage requests stall (load-use hazard)
- `stallreq_ex_i` input 1: ex stage requests stall (multi-cycle op)
- `stallreq_mem_i` input 1: mem stage requests stall (bus wait)
- `excp_req_i` input 1: mem stage signals committed exception or eret
- `excp_is_eret_i` input 1: qualifies `excp_req_i` as eret
- `epc_i` input 32: return PC for eret
- `stall` output 6: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb; 1 = stop
- `flush` output 1: registered; clears all pipeline registers
- `new_pc` output 32: registered redirect target, valid while `flush`=1
- `stall_total_o` output 32: saturating count of cycles with `stall[0]`=1
- `wdog_err_o` output 1: sticky stuck-stall error

## Operation
- State machine: RUN, FLUSH.
- RUN, stall vector from the highest requesting stage (combinational from requests):
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else 6'b000000
- Stall vector is always prefix-monotone: `stall[k]`=1 implies `stall[j]`=1 for all j<k. `stall[5]` is never set.
- RUN with `excp_req_i`=1 at a clock edge → FLUSH.
  - Registers `new_pc` = `epc_i` if `excp_is_eret_i`, else `EXC_VECTOR`.
  - `excp_req_i` takes effect even if stall requests are active that cycle. The stall vector in that cycle is still computed from the requests.
- FLUSH, one cycle:
  - `flush`=1, `stall`=6'b000000 regardless of requests.
  - `excp_req_i` and stall requests are ignored.
  - Unconditionally → RUN.
- `new_pc` holds its last value after FLUSH. It is only meaningful while `flush`=1.
- `stall_total_o`: +1 every cycle `stall[0]`=1; saturates at 32'hFFFF_FFFF.
- Watchdog run counter, internal, width ≥ clog2(`WDOG_LIMIT`)+1:
  - +1 each cycle `stall[0]`=1.
  - Cleared when `stall[0]`=0 or in FLUSH.
  - When the count reaches `WDOG_LIMIT`, `wdog_err_o` sets the next cycle and stays 1 until `rst`.
  - Counter saturates and does not wrap.

## Timing
- `stall`: zero latency from request inputs; forced to 0 while `rst`=1 and in FLUSH.
- `flush`/`new_pc`: asserted exactly one cycle after the edge sampling `excp_req_i`=1; `flush` is high for exactly one cycle.
- Back-to-back: `excp_req_i` held high across FLUSH produces a second flush only after at least one RUN cycle (minimum flush spacing 2 cycles).
- Reset values (all outputs, after a `rst` edge):
  - `stall`=0, `flush`=0, `new_pc`=0, `stall_total_o`=0, `wdog_err_o`=0
  - state RUN, run counter 0
- Reset mid-FLUSH aborts the flush: `flush`=0 the following cycle.
- Simultaneous `stall[0]`=1 in RUN and `excp_req_i`: the stall cycle is counted. Both counters clear/hold in FLUSH (no increment, since `stall`=0).

## Test plan
- Reset, all requests 0 → `stall`=0, `flush`=0, `stall_total_o`=0, `wdog_err_o`=0.
- Priority: id only → 6'b000111; id+ex → 6'b001111; id+ex+mem → 6'b011111; release all → 0 the same cycle.
- `excp_req_i`=1, `excp_is_eret_i`=0 with `stallreq_ex_i`=1 → that cycle `stall`=6'b001111. Next cycle `flush`=1, `new_pc`=32'h20, `stall`=0. Following cycle `flush`=0, `stall`=6'b001111.
- eret with `epc_i`=32'h0000_1234 held high 3 cycles → `flush` pattern 1,0,1; `new_pc`=32'h1234 on each flush.
- `stallreq_id_i` held 63 cycles then dropped → `wdog_err_o`=0, `stall_total_o`=63. Hold 64 cycles → `wdog_err_o`=1 the next cycle and stays set after the request drops until `rst`.
- `rst` asserted during FLUSH → next cycle `flush`=0, `new_pc`=0, state RUN.
